line_buffer_multi: RTL and testbench



---
 rtl/line_buffer_multi.sv | 113 +++++++++++
 tb/tb_line_buffer_multi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/line_buffer_multi.sv
// Multi-line delay buffer: LINES cascaded single-clock RAMs give column-aligned
// taps of the current pixel and of the same column on up to LINES previous lines.
module line_buffer_multi #(
  parameter int WIDTH  = 11,
  parameter int ADDR_W = 11,
  parameter int LINES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ce,
  input  logic [WIDTH-1:0]           din,
  input  logic [ADDR_W:0]            h_size,
  output logic [(LINES+1)*WIDTH-1:0] dout,
  output logic [LINES:0]             tap_valid,
  output logic [ADDR_W-1:0]          col,
  output logic                       eol
);

  localparam logic [ADDR_W:0] H_MIN = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] H_MAX = (ADDR_W+1)'(1) << ADDR_W;

  logic [ADDR_W:0]        addr_r;
  logic [ADDR_W-1:0]      addr_d_r;
  logic [ADDR_W:0]        h_eff_r;
  logic [ADDR_W:0]        h_clamp_s;
  logic [3:0]             fill_r;
  logic                   wrap_s;
  logic [WIDTH-1:0]       tap0_r;
  logic [LINES*WIDTH-1:0] ram_q_s;

  // Clamp the requested line length and detect the last column of the line.
  always_comb begin
    h_clamp_s = h_size;
    if (h_size < H_MIN) begin
      h_clamp_s = H_MIN;
    end else if (h_size > H_MAX) begin
      h_clamp_s = H_MAX;
    end else begin
      h_clamp_s = h_size;
    end
    wrap_s = (addr_r == (h_eff_r - (ADDR_W+1)'(1)));
  end

  // Column counter, line-length latch, fill counter and registered side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r    <= {(ADDR_W+1){1'b0}};
      addr_d_r  <= {ADDR_W{1'b0}};
      h_eff_r   <= h_clamp_s;
      fill_r    <= 4'd0;
      tap0_r    <= {WIDTH{1'b0}};
      tap_valid <= {(LINES+1){1'b0}};
      col       <= {ADDR_W{1'b0}};
      eol       <= 1'b0;
    end else if (ce) begin
      addr_d_r     <= addr_r[ADDR_W-1:0];
      col          <= addr_r[ADDR_W-1:0];
      eol          <= wrap_s;
      tap0_r       <= din;
      tap_valid[0] <= 1'b1;
      for (int k = 1; k <= LINES; k++) begin
        tap_valid[k] <= (fill_r >= 4'(k));
      end
      if (wrap_s) begin
        addr_r  <= {(ADDR_W+1){1'b0}};
        h_eff_r <= h_clamp_s;
        if (fill_r < 4'(LINES)) begin
          fill_r <= fill_r + 4'd1;
        end
      end else begin
        addr_r <= addr_r + (ADDR_W+1)'(1);
      end
    end
  end

  // RAM 1 takes din at the live address; deeper RAMs take the previous RAM's
  // read data one ce-cycle later, so they use the delayed address to stay aligned.
  for (genvar k = 1; k <= LINES; k++) begin : g_ram
    logic [WIDTH-1:0]  mem [2**ADDR_W];
    logic [WIDTH-1:0]  q_r;
    logic [WIDTH-1:0]  wr_data_s;
    logic [ADDR_W-1:0] wr_addr_s;

    if (k == 1) begin : g_first
      assign wr_data_s = din;
      assign wr_addr_s = addr_r[ADDR_W-1:0];
    end else begin : g_next
      assign wr_data_s = ram_q_s[(k-2)*WIDTH +: WIDTH];
      assign wr_addr_s = addr_d_r;
    end

    // Contents survive reset; stale data is hidden by the read mask below.
    always_ff @(posedge clk) begin
      if (ce && !rst) begin
        mem[wr_addr_s] <= wr_data_s;
      end
    end

    // Read-first registered port; taps of lines not yet filled read as zero.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_r <= {WIDTH{1'b0}};
      end else if (ce) begin
        q_r <= (fill_r >= 4'(k)) ? mem[addr_r[ADDR_W-1:0]] : {WIDTH{1'b0}};
      end
    end

    assign ram_q_s[(k-1)*WIDTH +: WIDTH] = q_r;
  end

  assign dout = {ram_q_s, tap0_r};

endmodule

// File: tb/tb_line_buffer_multi.sv
// Directed bench for line_buffer_multi with LINES=2 and full 2048-pixel depth.
module tb_line_buffer_multi;
  localparam int WIDTH  = 11;
  localparam int ADDR_W = 11;
  localparam int LINES  = 2;

  logic                       clk = 1'b0;
  logic                       rst, ce;
  logic [WIDTH-1:0]           din;
  logic [ADDR_W:0]            h_size;
  logic [(LINES+1)*WIDTH-1:0] dout;
  logic [LINES:0]             tap_valid;
  logic [ADDR_W-1:0]          col;
  logic                       eol;
  logic [WIDTH-1:0]           t0, t1, t2;

  int vectors = 0;
  int errors  = 0;

  line_buffer_multi #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .LINES(LINES)) dut (
    .clk(clk), .rst(rst), .ce(ce), .din(din), .h_size(h_size),
    .dout(dout), .tap_valid(tap_valid), .col(col), .eol(eol)
  );

  always #5 clk = ~clk;

  assign t0 = dout[0*WIDTH +: WIDTH];
  assign t1 = dout[1*WIDTH +: WIDTH];
  assign t2 = dout[2*WIDTH +: WIDTH];

  task automatic step(input logic r, input logic c, input logic [WIDTH-1:0] d);
    rst = r; ce = c; din = d;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    h_size = 12'd8;
    step(1'b1, 1'b0, 11'd0);
    step(1'b1, 1'b0, 11'd0);
    vectors++; if (dout !== 33'd0) begin errors++; $display("FAIL reset_dout: got %h expected 0", dout); end
    vectors++; if (tap_valid !== 3'b000) begin errors++; $display("FAIL reset_valid: got %b expected 000", tap_valid); end
    vectors++; if (col !== 11'd0) begin errors++; $display("FAIL reset_col: got %0d expected 0", col); end
    vectors++; if (eol !== 1'b0) begin errors++; $display("FAIL reset_eol: got %b expected 0", eol); end
  endtask

  task automatic test_fill;
    logic [WIDTH-1:0] e1, e2;
    logic [2:0] ev;
    h_size = 12'd8;
    step(1'b1, 1'b0, 11'd0);
    for (int n = 0; n < 26; n++) begin
      step(1'b0, 1'b1, WIDTH'(n));
      e1 = (n >= 8)  ? WIDTH'(n - 8)  : 11'd0;
      e2 = (n >= 16) ? WIDTH'(n - 16) : 11'd0;
      ev = (n >= 16) ? 3'b111 : ((n >= 8) ? 3'b011 : 3'b001);
      vectors++;
      if ({t2, t1, t0} !== {e2, e1, WIDTH'(n)}) begin
        errors++; $display("FAIL fill_taps n=%0d: got %0d/%0d/%0d expected %0d/%0d/%0d", n, t2, t1, t0, e2, e1, n);
      end
      vectors++;
      if (tap_valid !== ev) begin errors++; $display("FAIL fill_valid n=%0d: got %b expected %b", n, tap_valid, ev); end
      vectors++;
      if (col !== ADDR_W'(n % 8) || eol !== ((n % 8) == 7)) begin
        errors++; $display("FAIL fill_col n=%0d: got col %0d eol %b expected col %0d eol %b", n, col, eol, n % 8, (n % 8) == 7);
      end
    end
  endtask

  task automatic test_ce_toggle;
    int m;
    logic [WIDTH-1:0] e1;
    h_size = 12'd8;
    step(1'b1, 1'b0, 11'd0);
    m = -1;
    for (int i = 0; i < 40; i++) begin
      if (i % 2 == 0) begin
        m++;
        step(1'b0, 1'b1, WIDTH'(m + 30));
      end else begin
        step(1'b0, 1'b0, 11'h7FF);
      end
      e1 = (m >= 8) ? WIDTH'(m - 8 + 30) : 11'd0;
      vectors++;
      if (t0 !== WIDTH'(m + 30) || t1 !== e1 || col !== ADDR_W'(m % 8)) begin
        errors++; $display("FAIL ce_toggle i=%0d: got t0 %0d t1 %0d col %0d expected %0d %0d %0d", i, t0, t1, col, m + 30, e1, m % 8);
      end
    end
  endtask

  task automatic test_hsize_change;
    int ec;
    logic ee;
    h_size = 12'd8;
    step(1'b1, 1'b0, 11'd0);
    for (int n = 0; n < 23; n++) begin
      if (n == 3) h_size = 12'd5;
      step(1'b0, 1'b1, WIDTH'(n));
      ec = (n < 8) ? n : (n - 8) % 5;
      ee = (n == 7) || (n >= 8 && ec == 4);
      vectors++;
      if (col !== ADDR_W'(ec) || eol !== ee) begin
        errors++; $display("FAIL hsize_change n=%0d: got col %0d eol %b expected col %0d eol %b", n, col, eol, ec, ee);
      end
    end
  endtask

  task automatic test_small_h;
    logic [WIDTH-1:0] e1;
    logic [2:0] ev;
    for (int hv = 0; hv < 2; hv++) begin
      h_size = 12'(hv);
      step(1'b1, 1'b0, 11'd0);
      for (int n = 0; n < 8; n++) begin
        step(1'b0, 1'b1, WIDTH'(n + 50));
        e1 = (n >= 2) ? WIDTH'(n - 2 + 50) : 11'd0;
        ev = (n >= 4) ? 3'b111 : ((n >= 2) ? 3'b011 : 3'b001);
        vectors++;
        if (col !== ADDR_W'(n % 2) || eol !== ((n % 2) == 1) || t1 !== e1 || tap_valid !== ev) begin
          errors++; $display("FAIL small_h h=%0d n=%0d: got col %0d eol %b t1 %0d v %b expected %0d %b %0d %b",
                             hv, n, col, eol, t1, tap_valid, n % 2, (n % 2) == 1, e1, ev);
        end
      end
    end
  endtask

  task automatic test_full_depth;
    h_size = 12'd2048;
    step(1'b1, 1'b0, 11'd0);
    for (int n = 0; n < 2056; n++) begin
      step(1'b0, 1'b1, WIDTH'(n * 7 + 3));
      if (n == 2046 || n == 2047) begin
        vectors++;
        if (eol !== (n == 2047) || col !== ADDR_W'(n) || tap_valid !== 3'b001) begin
          errors++; $display("FAIL full_depth_eol n=%0d: got col %0d eol %b v %b expected col %0d eol %b v 001",
                             n, col, eol, tap_valid, n, n == 2047);
        end
      end
      if (n >= 2048) begin
        vectors++;
        if (t1 !== WIDTH'((n - 2048) * 7 + 3) || col !== ADDR_W'(n - 2048) || eol !== 1'b0 || tap_valid !== 3'b011) begin
          errors++; $display("FAIL full_depth_wrap n=%0d: got t1 %0d col %0d eol %b v %b expected %0d %0d 0 011",
                             n, t1, col, eol, tap_valid, WIDTH'((n - 2048) * 7 + 3), n - 2048);
        end
      end
    end
  endtask

  task automatic test_reset_midline;
    logic [WIDTH-1:0] e1;
    h_size = 12'd8;
    step(1'b1, 1'b0, 11'd0);
    for (int n = 0; n < 30; n++) step(1'b0, 1'b1, WIDTH'(n + 400));
    step(1'b1, 1'b0, 11'd0);
    vectors++;
    if (dout !== 33'd0 || tap_valid !== 3'b000 || col !== 11'd0 || eol !== 1'b0) begin
      errors++; $display("FAIL midline_reset: got dout %h v %b col %0d eol %b expected 0 000 0 0", dout, tap_valid, col, eol);
    end
    for (int n = 0; n < 12; n++) begin
      step(1'b0, 1'b1, WIDTH'(n + 200));
      e1 = (n >= 8) ? WIDTH'(n - 8 + 200) : 11'd0;
      vectors++;
      if (t0 !== WIDTH'(n + 200) || t1 !== e1 || t2 !== 11'd0 || tap_valid !== ((n >= 8) ? 3'b011 : 3'b001)) begin
        errors++; $display("FAIL midline_refill n=%0d: got %0d/%0d/%0d v %b expected 0/%0d/%0d", n, t2, t1, t0, tap_valid, e1, n + 200);
      end
    end
  endtask

  task automatic test_reset_at_wrap;
    h_size = 12'd8;
    step(1'b1, 1'b0, 11'd0);
    for (int n = 0; n < 15; n++) step(1'b0, 1'b1, WIDTH'(n + 600));
    step(1'b1, 1'b1, 11'h123);
    vectors++;
    if (dout !== 33'd0 || tap_valid !== 3'b000 || col !== 11'd0 || eol !== 1'b0) begin
      errors++; $display("FAIL wrap_reset: got dout %h v %b col %0d eol %b expected 0 000 0 0", dout, tap_valid, col, eol);
    end
    step(1'b0, 1'b1, 11'd5);
    vectors++;
    if (t0 !== 11'd5 || t1 !== 11'd0 || t2 !== 11'd0 || tap_valid !== 3'b001 || col !== 11'd0) begin
      errors++; $display("FAIL wrap_first: got %0d/%0d/%0d v %b col %0d expected 0/0/5 001 0", t2, t1, t0, tap_valid, col);
    end
    for (int n = 1; n < 9; n++) step(1'b0, 1'b1, WIDTH'(n + 5));
    vectors++;
    if (t1 !== 11'd5 || t2 !== 11'd0 || tap_valid !== 3'b011 || col !== 11'd0) begin
      errors++; $display("FAIL wrap_line1: got t2 %0d t1 %0d v %b col %0d expected 0 5 011 0", t2, t1, tap_valid, col);
    end
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; din = 11'd0; h_size = 12'd8;
    test_reset;
    test_fill;
    test_ce_toggle;
    test_hsize_change;
    test_small_h;
    test_full_depth;
    test_reset_midline;
    test_reset_at_wrap;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
